axi_lite_master_queue: RTL and testbench

- Parametrised successor to the separate single-shot AXI-lite read and write handlers.
- Accepts read and write requests from the scheduled datapath on a valid/ready port and queues them in an internal request FIFO of DEPTH entries.
- Issues the requests strictly in order as AXI4-lite transactions, one outstanding at a time. AW and W handshakes are tracked independently.
- Returns each completion, with data and response code, on a valid/ready response port. It sits between generated HLS control and an AXI-lite slave (RAM or register bank).

---
 rtl/axi_lite_master_queue.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_master_queue.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_queue.sv
// axi_lite_master_queue
// Queues read/write requests from the scheduled datapath in a DEPTH-entry FIFO
// and issues them in order as AXI4-lite transactions, one outstanding at a time.
// Each completion is returned with data and response code on a valid/ready port.
// Optional feature macro: AXI_TIMEOUT_EN adds a per-phase wait limit of
// TIMEOUT_CYCLES; on expiry the transaction completes with SLVERR (2'b10).
module axi_lite_master_queue #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_data,
    input  logic [STRB_WIDTH-1:0]   req_strb,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_resp,

    output logic                    busy,

    output logic [ADDR_WIDTH+1:0]   m_axil_awaddr,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    input  logic [1:0]              m_axil_bresp,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    output logic [ADDR_WIDTH+1:0]   m_axil_araddr,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

    // Reject configurations the FIFO pointer arithmetic cannot handle.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of 2 and at least 2");
        end
        if (DATA_WIDTH % 8 != 0 || STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_width
            $error("DATA_WIDTH must be a multiple of 8 and STRB_WIDTH = DATA_WIDTH/8");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    // ------------------------------------------------------------------
    // Request FIFO: entry = {write, addr, data, strb}
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    head_entry;
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;
    logic [STRB_WIDTH-1:0] head_strb;

    state_t                state_reg;

    assign fifo_full  = (count_reg == CNT_W'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign pop        = (state_reg == IDLE) && !fifo_empty;

    assign head_entry = fifo_mem[rd_ptr_reg];
    assign head_write = head_entry[ENTRY_W-1];
    assign head_addr  = head_entry[ENTRY_W-2 -: ADDR_WIDTH];
    assign head_data  = head_entry[STRB_WIDTH +: DATA_WIDTH];
    assign head_strb  = head_entry[STRB_WIDTH-1:0];

    // Storage array: written on push, no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {req_write, req_addr, req_data, req_strb};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transaction state
    // ------------------------------------------------------------------
    logic                  cur_write_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic [ADDR_WIDTH+1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_WIDTH-1:0] wstrb_reg;
    logic [ADDR_WIDTH+1:0] araddr_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  bready_reg;
    logic                  arvalid_reg;
    logic                  rready_reg;
    logic                  rsp_valid_reg;
    logic                  rsp_write_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [1:0]            rsp_resp_reg;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  in_wait;
    logic                  phase_done;
    logic                  timeout_hit;

    assign aw_hs = awvalid_reg && m_axil_awready;
    assign w_hs  = wvalid_reg && m_axil_wready;

    assign in_wait = (state_reg == WR_REQ) || (state_reg == WR_RESP) ||
                     (state_reg == RD_REQ) || (state_reg == RD_RESP);

    // The handshake that ends the current AXI phase, if it happens this cycle.
    always_comb begin
        phase_done = 1'b0;
        case (state_reg)
            WR_REQ:  phase_done = (aw_done_reg || aw_hs) && (w_done_reg || w_hs);
            WR_RESP: phase_done = bready_reg && m_axil_bvalid;
            RD_REQ:  phase_done = arvalid_reg && m_axil_arready;
            RD_RESP: phase_done = rready_reg && m_axil_rvalid;
            default: phase_done = 1'b0;
        endcase
    end

`ifdef AXI_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] phase_cnt_reg;

    // Counts cycles spent waiting in the current phase; restarts on each new phase.
    always_ff @(posedge clk) begin
        if (!rst || !in_wait || phase_done) begin
            phase_cnt_reg <= '0;
        end else begin
            phase_cnt_reg <= phase_cnt_reg + TO_W'(1);
        end
    end

    assign timeout_hit = in_wait && !phase_done &&
                         (phase_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Main sequencer: one AXI-lite transaction at a time, all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cur_write_reg <= 1'b0;
            aw_done_reg   <= 1'b0;
            w_done_reg    <= 1'b0;
            awaddr_reg    <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            araddr_reg    <= '0;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_write_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_resp_reg  <= 2'b00;
        end else if (timeout_hit) begin
            // Abandon the phase: release the bus and report SLVERR.
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_write_reg <= cur_write_reg;
            rsp_data_reg  <= '0;
            rsp_resp_reg  <= 2'b10;
            state_reg     <= RSP;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur_write_reg <= head_write;
                        aw_done_reg   <= 1'b0;
                        w_done_reg    <= 1'b0;
                        if (head_write) begin
                            awaddr_reg  <= {head_addr, 2'b00};
                            wdata_reg   <= head_data;
                            wstrb_reg   <= head_strb;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WR_REQ;
                        end else begin
                            araddr_reg  <= {head_addr, 2'b00};
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if (phase_done) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (phase_done) begin
                        bready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= 1'b1;
                        rsp_data_reg  <= '0;
                        rsp_resp_reg  <= m_axil_bresp;
                        state_reg     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (phase_done) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (phase_done) begin
                        rready_reg    <= 1'b0;
                        rsp_valid_reg <= 1'b1;
                        rsp_write_reg <= 1'b0;
                        rsp_data_reg  <= m_axil_rdata;
                        rsp_resp_reg  <= m_axil_rresp;
                        state_reg     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy           = !fifo_empty || (state_reg != IDLE);

    assign m_axil_awaddr  = awaddr_reg;
    assign m_axil_awvalid = awvalid_reg;
    assign m_axil_wdata   = wdata_reg;
    assign m_axil_wstrb   = wstrb_reg;
    assign m_axil_wvalid  = wvalid_reg;
    assign m_axil_bready  = bready_reg;
    assign m_axil_araddr  = araddr_reg;
    assign m_axil_arvalid = arvalid_reg;
    assign m_axil_rready  = rready_reg;

    assign rsp_valid      = rsp_valid_reg;
    assign rsp_write      = rsp_write_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_resp       = rsp_resp_reg;

endmodule

// File: tb/tb_axi_lite_master_queue.sv
// Directed testbench for axi_lite_master_queue with a small AXI-lite slave model
// (word RAM with byte strobes, programmable AW/W wait states, address stall,
// forced read response and a dead-slave mode for the AXI_TIMEOUT_EN build).
module tb_axi_lite_master_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        busy;

    logic [6:0]  awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [6:0]  araddr;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axi_lite_master_queue #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .STRB_WIDTH(4), .DEPTH(4), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_resp(rsp_resp), .busy(busy),
        .m_axil_awaddr(awaddr), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid),
        .m_axil_wready(wready), .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_araddr(araddr), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    // ---------------- slave model ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    logic        dead = 1'b0;
    logic        stall = 1'b0;
    logic        force_r = 1'b0;
    logic [1:0]  force_rresp = 2'b00;
    logic [31:0] force_rdata = '0;

    int          aw_wait, w_wait;
    int          aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, awv_cyc = 0, wv_cyc = 0;
    logic [6:0]  last_awaddr;
    logic [31:0] last_wdata;
    logic [3:0]  s_wstrb;
    logic        s_aw_have, s_w_have;
    logic [31:0] smem [32];

    assign awready = !dead && !stall && awvalid && (aw_wait >= aw_delay);
    assign wready  = !dead && !stall && wvalid && (w_wait >= w_delay);
    assign arready = !dead && !stall && arvalid;

    always @(posedge clk) begin
        if (!rst) begin
            aw_wait   <= 0;
            w_wait    <= 0;
            s_aw_have <= 1'b0;
            s_w_have  <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= 2'b00;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= 2'b00;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid && !wready) ? w_wait + 1 : 0;
            if (awvalid) awv_cyc <= awv_cyc + 1;
            if (wvalid)  wv_cyc  <= wv_cyc + 1;
            if (awvalid && awready) begin
                last_awaddr <= awaddr;
                s_aw_have   <= 1'b1;
                aw_hs_n     <= aw_hs_n + 1;
            end
            if (wvalid && wready) begin
                last_wdata <= wdata;
                s_wstrb    <= wstrb;
                s_w_have   <= 1'b1;
                w_hs_n     <= w_hs_n + 1;
            end
            if (s_aw_have && s_w_have && !bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) smem[last_awaddr[6:2]][8*b +: 8] <= last_wdata[8*b +: 8];
                bvalid    <= 1'b1;
                bresp     <= 2'b00;
                s_aw_have <= 1'b0;
                s_w_have  <= 1'b0;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                b_hs_n <= b_hs_n + 1;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= force_r ? force_rdata : smem[araddr[6:2]];
                rresp  <= force_r ? force_rresp : 2'b00;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output int waits);
        req_write = w; req_addr = a; req_data = d; req_strb = s; req_valid = 1'b1;
        waits = 0;
        while (!req_ready && waits < 100) begin
            @(posedge clk); #1;
            waits++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("req: write=%0b addr=%0d data=%h strb=%h waits=%0d", w, a, d, s, waits);
    endtask

    task automatic get_rsp(output logic w, output logic [31:0] d, output logic [1:0] r,
                           output bit ok);
        w = 1'bx; d = 'x; r = 'x; ok = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (rsp_valid) begin
                w = rsp_write; d = rsp_data; r = rsp_resp; ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        $display("rsp: got=%0b write=%0b data=%h resp=%0d", ok, w, d, r);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            bad++; $display("FAIL reset_handshakes got=%b want=000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
        total++; if ({rsp_write, rsp_data, rsp_resp} !== 35'h0) begin
            bad++; $display("FAIL reset_rsp_fields got=%b/%h/%b want=0/0/0", rsp_write, rsp_data, rsp_resp); end
        total++; if ({awaddr, araddr, wdata, wstrb} !== 50'h0) begin
            bad++; $display("FAIL reset_addr_data got=%h/%h/%h/%h want=0", awaddr, araddr, wdata, wstrb); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_release got busy=%b ready=%b want 0/1", busy, req_ready); end
    endtask

    task automatic test_write_read();
        int waits; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        push(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, waits);
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b1 || d !== 32'h0 || r !== 2'b00) begin
            bad++; $display("FAIL wr_rsp got ok=%0b w=%b d=%h r=%b want 1/1/0/00", ok, w, d, r); end
        total++; if (last_awaddr !== 7'h14) begin bad++; $display("FAIL wr_awaddr got=%h want=14", last_awaddr); end
        total++; if (last_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_wdata got=%h want=deadbeef", last_wdata); end
        push(1'b0, 5'd5, 32'h0, 4'h0, waits);
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b0 || d !== 32'hDEADBEEF || r !== 2'b00) begin
            bad++; $display("FAIL rd_rsp got ok=%0b w=%b d=%h r=%b want 1/0/deadbeef/00", ok, w, d, r); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_wait_states();
        int waits, awv0, wv0, b0, aw0; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        aw_delay = 3; w_delay = 1;
        awv0 = awv_cyc; wv0 = wv_cyc; b0 = b_hs_n; aw0 = aw_hs_n;
        push(1'b1, 5'd9, 32'h0BADF00D, 4'hF, waits);
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b1 || r !== 2'b00) begin
            bad++; $display("FAIL ws_rsp got ok=%0b w=%b r=%b want 1/1/00", ok, w, r); end
        total++; if (awv_cyc - awv0 != 4) begin bad++; $display("FAIL ws_awvalid_cycles got=%0d want=4", awv_cyc - awv0); end
        total++; if (wv_cyc - wv0 != 2) begin bad++; $display("FAIL ws_wvalid_cycles got=%0d want=2", wv_cyc - wv0); end
        total++; if (b_hs_n - b0 != 1 || aw_hs_n - aw0 != 1) begin
            bad++; $display("FAIL ws_single_b got b=%0d aw=%0d want 1/1", b_hs_n - b0, aw_hs_n - aw0); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL ws_extra_rsp got=%b want=0", rsp_valid); end
        aw_delay = 0; w_delay = 0;
    endtask

    task automatic test_fifo_full();
        logic        tw [6];
        logic [4:0]  ta [6];
        logic [31:0] td [6];
        logic [3:0]  ts [6];
        logic        ew [6];
        logic [31:0] ed [6];
        int waits; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        tw[0] = 1; ta[0] = 3;  td[0] = 32'h11223344; ts[0] = 4'hF; ew[0] = 1; ed[0] = 32'h0;
        tw[1] = 1; ta[1] = 3;  td[1] = 32'hAABBCCDD; ts[1] = 4'h5; ew[1] = 1; ed[1] = 32'h0;
        tw[2] = 0; ta[2] = 3;  td[2] = 32'h0;        ts[2] = 4'h0; ew[2] = 0; ed[2] = 32'h11BB33DD;
        tw[3] = 1; ta[3] = 10; td[3] = 32'hCAFEF00D; ts[3] = 4'hF; ew[3] = 1; ed[3] = 32'h0;
        tw[4] = 0; ta[4] = 10; td[4] = 32'h0;        ts[4] = 4'h0; ew[4] = 0; ed[4] = 32'hCAFEF00D;
        tw[5] = 0; ta[5] = 3;  td[5] = 32'h0;        ts[5] = 4'h0; ew[5] = 0; ed[5] = 32'h11BB33DD;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(tw[i], ta[i], td[i], ts[i], waits);
            total++; if (waits != 0) begin bad++; $display("FAIL ff_accept%0d got waits=%0d want=0", i, waits); end
        end
        total++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL ff_full got ready=%b busy=%b want 0/1", req_ready, busy); end
        req_write = tw[5]; req_addr = ta[5]; req_data = td[5]; req_strb = ts[5]; req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL ff_blocked got ready=%b want=0", req_ready); end
        stall = 1'b0;
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== ew[0] || d !== ed[0] || r !== 2'b00) begin
            bad++; $display("FAIL ff_rsp0 got ok=%0b w=%b d=%h r=%b", ok, w, d, r); end
        waits = 0;
        while (!req_ready && waits < 50) begin @(posedge clk); #1; waits++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        $display("req: write=%0b addr=%0d data=%h strb=%h waits=%0d", tw[5], ta[5], td[5], ts[5], waits);
        total++; if (waits >= 50) begin bad++; $display("FAIL ff_fifth_accept got waits=%0d want<50", waits); end
        for (int i = 1; i < 6; i++) begin
            get_rsp(w, d, r, ok);
            total++; if (!ok || w !== ew[i] || d !== ed[i] || r !== 2'b00) begin
                bad++; $display("FAIL ff_rsp%0d got ok=%0b w=%b d=%h r=%b want w=%b d=%h r=00", i, ok, w, d, r, ew[i], ed[i]); end
        end
    endtask

    task automatic test_error_resp();
        int waits; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        force_r = 1'b1; force_rresp = 2'b10; force_rdata = 32'h00001234;
        push(1'b0, 5'd1, 32'h0, 4'h0, waits);
        push(1'b1, 5'd2, 32'h00000055, 4'hF, waits);
        get_rsp(w, d, r, ok);
        force_r = 1'b0;
        total++; if (!ok || w !== 1'b0 || d !== 32'h1234 || r !== 2'b10) begin
            bad++; $display("FAIL err_rsp got ok=%0b w=%b d=%h r=%b want 1/0/1234/10", ok, w, d, r); end
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b1 || r !== 2'b00) begin
            bad++; $display("FAIL err_next got ok=%0b w=%b r=%b want 1/1/00", ok, w, r); end
        push(1'b0, 5'd2, 32'h0, 4'h0, waits);
        get_rsp(w, d, r, ok);
        total++; if (!ok || d !== 32'h55) begin bad++; $display("FAIL err_readback got=%h want=55", d); end
    endtask

    task automatic test_rsp_hold();
        int waits, n, aw0; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        push(1'b0, 5'd10, 32'h0, 4'h0, waits);
        push(1'b1, 5'd11, 32'h00000077, 4'hF, waits);
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL hold_wait got rsp_valid=%b want=1", rsp_valid); end
        aw0 = aw_hs_n;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b1 || rsp_write !== 1'b0 || rsp_data !== 32'hCAFEF00D || rsp_resp !== 2'b00) begin
                bad++; $display("FAIL hold_cycle%0d got v=%b w=%b d=%h r=%b want 1/0/cafef00d/00", i, rsp_valid, rsp_write, rsp_data, rsp_resp); end
            total++; if (awvalid !== 1'b0 || arvalid !== 1'b0) begin
                bad++; $display("FAIL hold_axi%0d got aw=%b ar=%b want 0/0", i, awvalid, arvalid); end
        end
        total++; if (aw_hs_n != aw0) begin bad++; $display("FAIL hold_no_issue got=%0d want=%0d", aw_hs_n, aw0); end
        get_rsp(w, d, r, ok);
        total++; if (!ok || d !== 32'hCAFEF00D) begin bad++; $display("FAIL hold_rsp got=%h want=cafef00d", d); end
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b1) begin bad++; $display("FAIL hold_next got ok=%0b w=%b want 1/1", ok, w); end
    endtask

    task automatic test_reset_mid();
        int waits, n; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        aw_delay = 20;
        push(1'b1, 5'd4, 32'h00000099, 4'hF, waits);
        n = 0;
        while (!awvalid && n < 20) begin @(posedge clk); #1; n++; end
        total++; if (awvalid !== 1'b1) begin bad++; $display("FAIL rm_in_wr_req got awvalid=%b want=1", awvalid); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            bad++; $display("FAIL rm_valids got=%b want=000000", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}); end
        total++; if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL rm_state got busy=%b ready=%b want 0/1", busy, req_ready); end
        rst = 1'b1; aw_delay = 0;
        @(posedge clk); #1;
        push(1'b1, 5'd4, 32'h00000099, 4'hF, waits);
        get_rsp(w, d, r, ok);
        push(1'b0, 5'd4, 32'h0, 4'h0, waits);
        get_rsp(w, d, r, ok);
        total++; if (!ok || d !== 32'h99) begin bad++; $display("FAIL rm_recover got ok=%0b d=%h want 1/99", ok, d); end
    endtask

`ifdef AXI_TIMEOUT_EN
    task automatic test_timeout();
        int waits, n; logic w; logic [31:0] d; logic [1:0] r; bit ok;
        dead = 1'b1;
        push(1'b0, 5'd0, 32'h0, 4'h0, waits);
        n = 0;
        while (!arvalid && n < 20) begin @(posedge clk); #1; n++; end
        n = 0;
        while (!rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (n != 8) begin bad++; $display("FAIL to_cycles got=%0d want=8", n); end
        total++; if (rsp_resp !== 2'b10 || rsp_data !== 32'h0 || arvalid !== 1'b0) begin
            bad++; $display("FAIL to_rsp got r=%b d=%h ar=%b want 10/0/0", rsp_resp, rsp_data, arvalid); end
        dead = 1'b0;
        get_rsp(w, d, r, ok);
        total++; if (!ok || w !== 1'b0) begin bad++; $display("FAIL to_consume got ok=%0b w=%b want 1/0", ok, w); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_fifo_full();
        test_error_resp();
        test_rsp_hold();
        test_reset_mid();
`ifdef AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
